uvmt_cv32e40x_obi_mem_responder: RTL



---
 rtl/uvmt_cv32e40x_obi_mem_pkg.sv | 19 +
 rtl/uvmt_cv32e40x_obi_mem_responder_if.sv | 34 +++
 rtl/uvmt_cv32e40x_obi_rsp_fifo.sv | 57 +++++
 rtl/uvmt_cv32e40x_obi_mem_responder.sv | 95 +++++++++
 4 files changed

// File: rtl/uvmt_cv32e40x_obi_mem_pkg.sv
// Shared types, constants and helpers for the OBI memory responder.
package uvmt_cv32e40x_obi_mem_pkg;

  localparam int OBI_BE_W   = 4;
  localparam int OBI_ATOP_W = 6;

  // One response-phase beat as held in the response FIFO.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_rsp_t;

  // Word index of a byte address in a power-of-2 deep word memory.
  function automatic int unsigned word_index(input logic [31:0] addr,
                                             input int unsigned mem_words);
    return (addr >> 2) & (mem_words - 1);
  endfunction

endpackage

// File: rtl/uvmt_cv32e40x_obi_mem_responder_if.sv
// OBI bus bundle between a core initiator port and the memory responder.
interface uvmt_cv32e40x_obi_mem_responder_if #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) ();
  import uvmt_cv32e40x_obi_mem_pkg::*;

  logic                               req_i;
  logic                               gnt_o;
  logic [ADDR_WIDTH-1:0]              addr_i;
  logic                               we_i;
  logic [OBI_BE_W-1:0]                be_i;
  logic [DATA_WIDTH-1:0]              wdata_i;
  logic [OBI_ATOP_W-1:0]              atop_i;
  logic                               rvalid_o;
  logic [DATA_WIDTH-1:0]              rdata_o;
  logic                               err_o;
  logic                               exokay_o;
  logic                               gnt_stall_i;
  logic                               rsp_stall_i;
  logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i, atop_i, gnt_stall_i, rsp_stall_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, exokay_o, outstanding_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i, atop_i, gnt_stall_i, rsp_stall_i,
    output gnt_o, rvalid_o, rdata_o, err_o, exokay_o, outstanding_o
  );

endinterface

// File: rtl/uvmt_cv32e40x_obi_rsp_fifo.sv
// Synchronous FIFO holding pending responses; pointers carry a wrap bit.
module uvmt_cv32e40x_obi_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [IW-1:0]    w_widx;
  logic [IW-1:0]    w_ridx;
  logic [WIDTH-1:0] r_mem [DEPTH];

  if (DEPTH > 1) begin : g_idx
    assign w_widx = r_wptr[IW-1:0];
    assign w_ridx = r_rptr[IW-1:0];
  end else begin : g_idx_single
    assign w_widx = '0;
    assign w_ridx = '0;
  end

  assign empty_o = (r_wptr == r_rptr);
  assign full_o  = (r_wptr[PW-1] != r_rptr[PW-1]) && (w_widx == w_ridx);
  assign count_o = r_wptr - r_rptr;
  assign head_o  = r_mem[w_ridx];

  // Advance the pointers on push/pop; reset empties the FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      // NOTE: nonblocking assignments keep every flop sampling pre-edge values.
      if (push_i) r_wptr <= r_wptr + 1'b1;
      if (pop_i)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Store pushed entries.
  // NOTE: storage has no reset; validity comes solely from the pointers.
  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[w_widx] <= push_data_i;
  end

endmodule

// File: rtl/uvmt_cv32e40x_obi_mem_responder.sv
// OBI subordinate: grants requests, services them against a word memory and
// returns in-order, registered response beats.
module uvmt_cv32e40x_obi_mem_responder
  import uvmt_cv32e40x_obi_mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    MEM_WORDS       = 1024,
  parameter int                    MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] ERR_BASE        = ADDR_WIDTH'(32'hFFFF_F000)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  uvmt_cv32e40x_obi_mem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [DATA_WIDTH-1:0]            r_mem [MEM_WORDS];
  logic                             r_rvalid;
  logic [DATA_WIDTH-1:0]            r_rdata;
  logic                             r_err;

  logic                             w_full;
  logic                             w_empty;
  logic [$clog2(MAX_OUTSTANDING):0] w_count;
  logic                             w_accept;
  logic                             w_pop;
  logic                             w_err_hit;
  logic [IDX_W-1:0]                 w_idx;
  obi_rsp_t                         w_push_rsp;
  obi_rsp_t                         w_head;

  // A pop never frees a slot for a grant in the same cycle.
  assign bus.gnt_o = bus.req_i & ~bus.gnt_stall_i & ~w_full & ~rst_i;
  assign w_accept  = bus.req_i & bus.gnt_o;
  assign w_pop     = ~w_empty & ~bus.rsp_stall_i;
  assign w_idx     = IDX_W'(word_index(32'(bus.addr_i), MEM_WORDS));
  assign w_err_hit = (bus.addr_i >= ERR_BASE) | (bus.atop_i != '0);

  // Build the response for the transfer being accepted this cycle.
  always_comb begin
    // NOTE: assigning defaults first guarantees no latch on any path.
    w_push_rsp = '0;
    if (w_err_hit) begin
      w_push_rsp.err = 1'b1;
    end else if (!bus.we_i) begin
      w_push_rsp.rdata = r_mem[w_idx];
    end
  end

  // Byte-enabled writes to the memory; erroring transfers leave it untouched.
  always_ff @(posedge clk_i) begin
    if (w_accept && bus.we_i && !w_err_hit) begin
      for (int b = 0; b < OBI_BE_W; b++) begin
        if (bus.be_i[b]) r_mem[w_idx][8*b +: 8] <= bus.wdata_i[8*b +: 8];
      end
    end
  end

  uvmt_cv32e40x_obi_rsp_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH ($bits(obi_rsp_t))
  ) u_rsp_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_accept),
    .push_data_i (w_push_rsp),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .count_o     (w_count)
  );

  // Present the FIFO head as a one-cycle response beat; rdata holds between beats.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_pop;
      r_err    <= w_pop & w_head.err;
      if (w_pop) r_rdata <= w_head.rdata;
    end
  end

  assign bus.rvalid_o      = r_rvalid;
  assign bus.rdata_o       = r_rdata;
  assign bus.err_o         = r_err;
  assign bus.exokay_o      = 1'b0;
  assign bus.outstanding_o = w_count;

endmodule
